// File: rtl/boid_fb_pkg.sv
// ============================================================================
// boid_fb_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the boid occupancy framebuffer (read and write side).
//   - state_e        : swap-control FSM states of the scanout block
//   - *_DEF          : default grid / address / coordinate geometry
//   - SCAN_LATENCY   : beam x/y -> pixel_on latency of the scanout pipeline
// No ports (package).
// ============================================================================
package boid_fb_pkg;

    // Swap-control FSM states.
    typedef enum logic [1:0] {
        DISPLAY  = 2'd0,
        SWAP     = 2'd1,
        CLEARING = 2'd2
    } state_e;

    // Default geometry: 40x30 cells of 16x16 pixels -> 640x480.
    localparam int ADDR_WIDTH_DEF  = 11;
    localparam int GRID_W_DEF      = 40;
    localparam int GRID_H_DEF      = 30;
    localparam int SCALE_SHIFT_DEF = 4;
    localparam int COORD_WIDTH_DEF = 10;

    // Cycles from x/y presented to pixel_on valid.
    localparam int SCAN_LATENCY    = 2;

endpackage : boid_fb_pkg

// File: rtl/boid_frame_scanout_if.sv
// ============================================================================
// boid_frame_scanout_if
// ----------------------------------------------------------------------------
// Bundles the signals between the scanout block and its environment (VGA
// timing generator, boid writer, framebuffer RAM).
//   video_on, x_pos, y_pos, vblank : beam timing            (to scanout)
//   frame_ready / frame_ack        : writer handshake       (in / out)
//   read_addr / read_data          : framebuffer read port  (out / in)
//   swap                           : framebuffer buffer toggle pulse (out)
//   pixel_on, pixel_valid          : pixel stream           (out)
//   lit_count                      : only with BOID_SCANOUT_STATS_EN defined
// Modports:
//   slave  - the scanout block itself
//   master - the environment driving it
// ============================================================================
interface boid_frame_scanout_if #(
    parameter int ADDR_WIDTH  = boid_fb_pkg::ADDR_WIDTH_DEF,
    parameter int COORD_WIDTH = boid_fb_pkg::COORD_WIDTH_DEF
);

    logic                   video_on;
    logic [COORD_WIDTH-1:0] x_pos;
    logic [COORD_WIDTH-1:0] y_pos;
    logic                   vblank;
    logic                   frame_ready;
    logic                   read_data;
    logic [ADDR_WIDTH-1:0]  read_addr;
    logic                   swap;
    logic                   frame_ack;
    logic                   pixel_on;
    logic                   pixel_valid;
`ifdef BOID_SCANOUT_STATS_EN
    logic [ADDR_WIDTH:0]    lit_count;

    modport slave (
        input  video_on, x_pos, y_pos, vblank, frame_ready, read_data,
        output read_addr, swap, frame_ack, pixel_on, pixel_valid, lit_count
    );

    modport master (
        output video_on, x_pos, y_pos, vblank, frame_ready, read_data,
        input  read_addr, swap, frame_ack, pixel_on, pixel_valid, lit_count
    );
`else
    modport slave (
        input  video_on, x_pos, y_pos, vblank, frame_ready, read_data,
        output read_addr, swap, frame_ack, pixel_on, pixel_valid
    );

    modport master (
        output video_on, x_pos, y_pos, vblank, frame_ready, read_data,
        input  read_addr, swap, frame_ack, pixel_on, pixel_valid
    );
`endif

endinterface : boid_frame_scanout_if

// File: rtl/boid_cell_addr.sv
// ============================================================================
// boid_cell_addr
// ----------------------------------------------------------------------------
// Combinational mapper from screen coordinates to a framebuffer cell address.
// Shared between the scanout (read) side and the boid writer.
//   x_pos_i, y_pos_i : pixel coordinates
//   video_on_i       : coordinates are meaningful (beam in active area)
//   addr_o           : cy*GRID_W + cx, or 0 when not in range
//   in_range_o       : cell lies inside the grid and video_on_i is high
// ============================================================================
module boid_cell_addr
    import boid_fb_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int GRID_W      = GRID_W_DEF,
    parameter int GRID_H      = GRID_H_DEF,
    parameter int SCALE_SHIFT = SCALE_SHIFT_DEF,
    parameter int COORD_WIDTH = COORD_WIDTH_DEF
) (
    input  logic [COORD_WIDTH-1:0] x_pos_i,
    input  logic [COORD_WIDTH-1:0] y_pos_i,
    input  logic                   video_on_i,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    output logic                   in_range_o
);

    // One extra bit so an oversized grid cannot silently wrap into a valid address.
    localparam int CALC_W = ADDR_WIDTH + 1;

    logic [COORD_WIDTH-1:0] cx_s;
    logic [COORD_WIDTH-1:0] cy_s;
    logic [CALC_W-1:0]      addr_full_s;
    logic                   cell_ok_s;

    // Cell coordinates, linear index and range qualification.
    always_comb begin
        cx_s        = x_pos_i >> SCALE_SHIFT;
        cy_s        = y_pos_i >> SCALE_SHIFT;
        addr_full_s = CALC_W'(cy_s) * CALC_W'(GRID_W) + CALC_W'(cx_s);
        cell_ok_s   = video_on_i
                      && (cx_s < COORD_WIDTH'(GRID_W))
                      && (cy_s < COORD_WIDTH'(GRID_H))
                      && (addr_full_s[CALC_W-1] == 1'b0);
        if (cell_ok_s) begin
            addr_o     = addr_full_s[ADDR_WIDTH-1:0];
            in_range_o = 1'b1;
        end else begin
            addr_o     = '0;
            in_range_o = 1'b0;
        end
    end

endmodule : boid_cell_addr

// File: rtl/boid_frame_scanout.sv
// ============================================================================
// boid_frame_scanout
// ----------------------------------------------------------------------------
// Read side of the double-buffered 1-bit boid occupancy framebuffer.
//   - Maps the beam position to a cell read address (registered) and aligns
//     the RAM read data with the beam: pixel_on / pixel_valid follow x/y by
//     SCAN_LATENCY (2) cycles, with no bubbles in any FSM state.
//   - Owns buffer swapping: a one-cycle swap + frame_ack pulse, only in
//     vblank and only when the writer reports frame_ready, and never again
//     until the newly hidden buffer has been cleared (2**ADDR_WIDTH cycles).
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : boid_frame_scanout_if.slave (beam timing, writer handshake,
//            framebuffer read port, swap, pixel stream)
// Optional feature macro: BOID_SCANOUT_STATS_EN
//   Adds bus.lit_count = number of distinct lit cells seen (as runs of
//   consecutive lit pixels) in the frame that was just retired by a swap.
// ============================================================================
module boid_frame_scanout
    import boid_fb_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int GRID_W      = GRID_W_DEF,
    parameter int GRID_H      = GRID_H_DEF,
    parameter int SCALE_SHIFT = SCALE_SHIFT_DEF,
    parameter int COORD_WIDTH = COORD_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    boid_frame_scanout_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] CLEAR_LAST = {ADDR_WIDTH{1'b1}};

    // ------------------------------------------------------------------
    // Swap-control FSM
    // ------------------------------------------------------------------
    state_e                state_q;
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] clear_cnt_q;
    logic [ADDR_WIDTH-1:0] clear_cnt_d;
    logic                  swap_q;
    logic                  swap_d;

    // Next-state logic; swap_d is high exactly when SWAP is entered, so the
    // registered pulse coincides with the SWAP state and never glitches.
    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        swap_d      = 1'b0;
        case (state_q)
            DISPLAY: begin
                if (bus.vblank && bus.frame_ready) begin
                    state_d = SWAP;
                    swap_d  = 1'b1;
                end else begin
                    state_d = DISPLAY;
                end
            end
            SWAP: begin
                state_d     = CLEARING;
                clear_cnt_d = CLEAR_LAST;
            end
            CLEARING: begin
                // frame_ready is deliberately ignored until the clear is done.
                if (clear_cnt_q == '0) begin
                    state_d = DISPLAY;
                end else begin
                    clear_cnt_d = clear_cnt_q - ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d     = CLEARING;
                clear_cnt_d = CLEAR_LAST;
            end
        endcase
    end

    // FSM state, clear counter and swap pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEARING;
            clear_cnt_q <= CLEAR_LAST;
            swap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
            swap_q      <= swap_d;
        end
    end

    // ------------------------------------------------------------------
    // Scan pipeline: stage 1 = address, stage 2 = pixel
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]   cell_addr_s;
    logic                    in_range_s;
    logic [ADDR_WIDTH-1:0]   read_addr_q;
    logic                    in_range_q;
    logic [SCAN_LATENCY-1:0] video_pipe_q;   // [0] = video_on_d1, [1] = pixel_valid
    logic                    pixel_on_d;
    logic                    pixel_on_q;

    boid_cell_addr #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .GRID_W      (GRID_W),
        .GRID_H      (GRID_H),
        .SCALE_SHIFT (SCALE_SHIFT),
        .COORD_WIDTH (COORD_WIDTH)
    ) u_cell_addr (
        .x_pos_i    (bus.x_pos),
        .y_pos_i    (bus.y_pos),
        .video_on_i (bus.video_on),
        .addr_o     (cell_addr_s),
        .in_range_o (in_range_s)
    );

    // The RAM returns data for read_addr_q during stage 2; qualify it with
    // the stage-1 range and video flags that travelled alongside.
    always_comb begin
        pixel_on_d = bus.read_data & in_range_q & video_pipe_q[0];
    end

    // Pipeline registers; they advance every cycle regardless of FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_addr_q  <= '0;
            in_range_q   <= 1'b0;
            video_pipe_q <= '0;
            pixel_on_q   <= 1'b0;
        end else begin
            read_addr_q  <= cell_addr_s;
            in_range_q   <= in_range_s;
            video_pipe_q <= {video_pipe_q[SCAN_LATENCY-2:0], bus.video_on};
            pixel_on_q   <= pixel_on_d;
        end
    end

    assign bus.read_addr   = read_addr_q;
    assign bus.swap        = swap_q;
    assign bus.frame_ack   = swap_q;
    assign bus.pixel_on    = pixel_on_q;
    assign bus.pixel_valid = video_pipe_q[SCAN_LATENCY-1];

`ifdef BOID_SCANOUT_STATS_EN
    // ------------------------------------------------------------------
    // Lit-cell statistics
    // ------------------------------------------------------------------
    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [CNT_W-1:0]      lit_cnt_q;     // running count for the current frame
    logic [CNT_W-1:0]      lit_count_q;   // snapshot taken on swap
    logic [ADDR_WIDTH-1:0] last_lit_q;    // cell of the previous lit pixel
    logic                  have_lit_q;    // last_lit_q is meaningful this frame
    logic                  new_cell_s;

    // A lit pixel counts only when it lands on a different cell than the
    // previous lit pixel, so a 16-pixel-wide cell is counted once per run.
    always_comb begin
        new_cell_s = pixel_on_d && (!have_lit_q || (read_addr_q != last_lit_q));
    end

    // Running counter (saturating), snapshot on swap, restart for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            lit_cnt_q   <= '0;
            lit_count_q <= '0;
            last_lit_q  <= '0;
            have_lit_q  <= 1'b0;
        end else if (swap_d) begin
            lit_count_q <= lit_cnt_q;
            lit_cnt_q   <= '0;
            have_lit_q  <= 1'b0;
        end else if (new_cell_s) begin
            if (lit_cnt_q != {CNT_W{1'b1}}) begin
                lit_cnt_q <= lit_cnt_q + CNT_W'(1);
            end else begin
                lit_cnt_q <= lit_cnt_q;
            end
            last_lit_q <= read_addr_q;
            have_lit_q <= 1'b1;
        end else begin
            lit_cnt_q <= lit_cnt_q;
        end
    end

    assign bus.lit_count = lit_count_q;
`endif

endmodule : boid_frame_scanout
